// File: rtl/stopwatch_lap_pkg.sv
// Shared types and constants for the stopwatch with lap capture.
// Holds the run/pause FSM state encoding, the BCD digit and mm:ss.cc
// time record types, digit limits and the all-zero time constant.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  // Field order puts m1 in the most significant nibble of the 24-bit word.
  typedef struct packed {
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
    bcd_t c1;
    bcd_t c0;
  } time_t;

  localparam bcd_t  DIGIT_MAX9 = 4'd9;
  localparam bcd_t  DIGIT_MAX5 = 4'd5;
  localparam time_t ZERO_TIME  = '0;

  // Advance one digit, wrapping to zero at its limit. The >= guards
  // against ever carrying an out-of-range value forward.
  function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_lap_if.sv
// Control/status bundle of the stopwatch.
// master: drives the start/stop/clear/lap/lap_rd pulses, observes the time,
//         lap FIFO head, lap_valid, lap_count, lap_ovf, rollover, running.
// slave : the stopwatch itself (opposite directions).
interface stopwatch_lap_if #(
  parameter int NUM_LAPS = 4
);
  import stopwatch_pkg::*;

  logic                      start;
  logic                      stop;
  logic                      clear;
  logic                      lap;
  logic                      lap_rd;
  time_t                     time_bcd;
  time_t                     lap_bcd;
  logic                      lap_valid;
  logic [$clog2(NUM_LAPS):0] lap_count;
  logic                      lap_ovf;
  logic                      rollover;
  logic                      running;

  modport master (
    output start, stop, clear, lap, lap_rd,
    input  time_bcd, lap_bcd, lap_valid, lap_count, lap_ovf, rollover, running
  );

  modport slave (
    input  start, stop, clear, lap, lap_rd,
    output time_bcd, lap_bcd, lap_valid, lap_count, lap_ovf, rollover, running
  );

endinterface

// File: rtl/stopwatch_lap_bcd_time_counter.sv
// BCD mm:ss.cc counter advanced by one centisecond per tick.
// Ports: clk, reset (sync, active-high), clr (sync zero), tick (advance),
//        time_bcd (registered digits), rollover (one-cycle pulse on the
//        59:59.99 -> 00:00.00 wrap).
module bcd_time_counter
  import stopwatch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clr,
  input  logic  tick,
  output time_t time_bcd,
  output logic  rollover
);

  time_t time_q;
  time_t time_d;
  logic  carry_c1;
  logic  carry_s0;
  logic  carry_s1;
  logic  carry_m0;
  logic  carry_m1;
  logic  wrap;

  // Ripple carry: each digit advances only when every lower digit is at
  // its limit on a tick cycle.
  always_comb begin
    carry_c1 = tick     && (time_q.c0 == DIGIT_MAX9);
    carry_s0 = carry_c1 && (time_q.c1 == DIGIT_MAX9);
    carry_s1 = carry_s0 && (time_q.s0 == DIGIT_MAX9);
    carry_m0 = carry_s1 && (time_q.s1 == DIGIT_MAX5);
    carry_m1 = carry_m0 && (time_q.m0 == DIGIT_MAX9);
    wrap     = carry_m1 && (time_q.m1 == DIGIT_MAX5);

    time_d = time_q;
    if (tick)     time_d.c0 = bcd_inc(time_q.c0, DIGIT_MAX9);
    if (carry_c1) time_d.c1 = bcd_inc(time_q.c1, DIGIT_MAX9);
    if (carry_s0) time_d.s0 = bcd_inc(time_q.s0, DIGIT_MAX9);
    if (carry_s1) time_d.s1 = bcd_inc(time_q.s1, DIGIT_MAX5);
    if (carry_m0) time_d.m0 = bcd_inc(time_q.m0, DIGIT_MAX9);
    if (carry_m1) time_d.m1 = bcd_inc(time_q.m1, DIGIT_MAX5);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      time_q   <= ZERO_TIME;
      rollover <= 1'b0;
    end else begin
      time_q   <= time_d;
      rollover <= wrap;
    end
  end

  assign time_bcd = time_q;

endmodule

// File: rtl/stopwatch_lap.sv
// Stopwatch with run/pause/clear control, prescaled BCD time and a lap FIFO.
// Ports: clk, reset (sync, active-high), sw (stopwatch_lap_if.slave) carrying
//        the control pulses and all registered status/time outputs.
// Parameters: TICK_DIV clk cycles per centisecond, NUM_LAPS FIFO depth
//        (power of two), CNT_W prescaler width.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int NUM_LAPS = 4,
  parameter int CNT_W    = 19
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_lap_if.slave   sw
);

  localparam int PTR_W  = $clog2(NUM_LAPS);
  localparam int LCNT_W = PTR_W + 1;

  sw_state_t          state;
  sw_state_t          next_state;
  logic [CNT_W-1:0]   presc;
  logic               tick;
  logic               clr;
  time_t              cur_time;
  logic               rollover;
  time_t              fifo_mem [NUM_LAPS];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [LCNT_W-1:0]  count;
  logic               ovf;
  logic               full;
  logic               push_req;
  logic               push;
  logic               pop;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // clear outranks stop, stop outranks start; each pulse only matters in
  // the states where it has a defined transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sw.start) next_state = RUN;
      RUN:     if (sw.stop)  next_state = PAUSE;
      PAUSE: begin
        if (sw.clear)      next_state = IDLE;
        else if (sw.start) next_state = RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  assign clr  = (state == PAUSE) && sw.clear;
  assign tick = (state == RUN) && (presc == CNT_W'(TICK_DIV - 1));

  // Prescaler only moves in RUN, so a pause keeps the partial tick.
  always_ff @(posedge clk) begin
    if (reset || clr)      presc <= '0;
    else if (tick)         presc <= '0;
    else if (state == RUN) presc <= presc + CNT_W'(1);
  end

  bcd_time_counter u_time (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .tick     (tick),
    .time_bcd (cur_time),
    .rollover (rollover)
  );

  // A pop in the same cycle frees the slot, so a full FIFO can still
  // accept a lap; the write then lands in the slot just vacated.
  assign full     = (count == LCNT_W'(NUM_LAPS));
  assign push_req = (state == RUN) && sw.lap;
  assign pop      = sw.lap_rd && (count != '0);
  assign push     = push_req && (!full || pop);

  // Captures the pre-increment time on tick cycles.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cur_time;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + LCNT_W'(1);
      else if (pop && !push) count <= count - LCNT_W'(1);
      if (push_req && !push) ovf <= 1'b1;
    end
  end

  assign sw.time_bcd  = cur_time;
  assign sw.rollover  = rollover;
  assign sw.running   = (state == RUN);
  assign sw.lap_valid = (count != '0);
  assign sw.lap_bcd   = (count != '0) ? fifo_mem[rd_ptr] : ZERO_TIME;
  assign sw.lap_count = count;
  assign sw.lap_ovf   = ovf;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: a TICK_DIV=2 instance for run, laps,
// priority and reset cases, a TICK_DIV=4 instance for partial-tick resume,
// and a free-standing bcd_time_counter on a fast clock for the full wrap.
module tb_stopwatch_lap;
  import stopwatch_pkg::*;

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] START = 5'b10000;
  localparam logic [4:0] STOP  = 5'b01000;
  localparam logic [4:0] CLEAR = 5'b00100;
  localparam logic [4:0] LAP   = 5'b00010;
  localparam logic [4:0] RD    = 5'b00001;

  logic  clk   = 1'b0;
  logic  fclk  = 1'b0;
  logic  reset = 1'b1;
  logic  ctr_clr  = 1'b0;
  logic  ctr_tick = 1'b0;
  time_t ctr_time;
  logic  ctr_roll;

  int checks = 0;
  int errors = 0;

  always #10 clk  = ~clk;
  always #1  fclk = ~fclk;

  stopwatch_lap_if #(.NUM_LAPS(4)) sw2 ();
  stopwatch_lap_if #(.NUM_LAPS(4)) sw4 ();

  stopwatch_lap #(.TICK_DIV(2), .NUM_LAPS(4), .CNT_W(4)) dut2 (
    .clk   (clk),
    .reset (reset),
    .sw    (sw2)
  );

  stopwatch_lap #(.TICK_DIV(4), .NUM_LAPS(4), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .sw    (sw4)
  );

  bcd_time_counter u_ctr (
    .clk      (fclk),
    .reset    (reset),
    .clr      (ctr_clr),
    .tick     (ctr_tick),
    .time_bcd (ctr_time),
    .rollover (ctr_roll)
  );

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds {start,stop,clear,lap,lap_rd} for one sampled edge on each
  // instance, then idles for the given number of cycles.
  task automatic applyStimulus(input logic [4:0] ctl2, input logic [4:0] ctl4,
                               input int idle);
    {sw2.start, sw2.stop, sw2.clear, sw2.lap, sw2.lap_rd} = ctl2;
    {sw4.start, sw4.stop, sw4.clear, sw4.lap, sw4.lap_rd} = ctl4;
    waitCycles(1);
    {sw2.start, sw2.stop, sw2.clear, sw2.lap, sw2.lap_rd} = NONE;
    {sw4.start, sw4.stop, sw4.clear, sw4.lap, sw4.lap_rd} = NONE;
    waitCycles(idle);
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] observed,
                             input logic [23:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_time"},    sw2.time_bcd, 24'h0);
    checkOutput({tag, "_running"}, 24'(sw2.running), 24'h0);
    checkOutput({tag, "_valid"},   24'(sw2.lap_valid), 24'h0);
    checkOutput({tag, "_count"},   24'(sw2.lap_count), 24'h0);
    checkOutput({tag, "_lapbcd"},  sw2.lap_bcd, 24'h0);
    checkOutput({tag, "_ovf"},     24'(sw2.lap_ovf), 24'h0);
    checkOutput({tag, "_roll"},    24'(sw2.rollover), 24'h0);
  endtask

  initial begin
    logic [23:0] exp_heads [3];
    int          n;
    logic        bad_digit;
    logic        early_roll;

    {sw2.start, sw2.stop, sw2.clear, sw2.lap, sw2.lap_rd} = NONE;
    {sw4.start, sw4.stop, sw4.clear, sw4.lap, sw4.lap_rd} = NONE;
    reset = 1'b1;
    waitCycles(3);
    checkAllZero("reset");
    reset = 1'b0;
    waitCycles(1);

    $display("[TB] resume keeps partial tick (TICK_DIV=4)");
    applyStimulus(NONE, START, 3);
    checkOutput("div4_before_first_tick", sw4.time_bcd, 24'h000000);
    waitCycles(1);
    checkOutput("div4_first_tick", sw4.time_bcd, 24'h000001);
    waitCycles(1);
    applyStimulus(NONE, STOP, 5);
    checkOutput("div4_paused_running", 24'(sw4.running), 24'h0);
    checkOutput("div4_paused_time", sw4.time_bcd, 24'h000001);
    applyStimulus(NONE, START, 1);
    checkOutput("div4_resume_plus1", sw4.time_bcd, 24'h000001);
    waitCycles(1);
    checkOutput("div4_resume_plus2", sw4.time_bcd, 24'h000002);

    $display("[TB] basic run (TICK_DIV=2)");
    applyStimulus(START, NONE, 0);
    checkOutput("run_running", 24'(sw2.running), 24'h1);
    waitCycles(300);
    checkOutput("run_150_ticks", sw2.time_bcd, 24'h000150);
    applyStimulus(STOP, NONE, 0);
    checkOutput("stop_running", 24'(sw2.running), 24'h0);
    waitCycles(50);
    checkOutput("stop_frozen", sw2.time_bcd, 24'h000150);

    applyStimulus(CLEAR | START, NONE, 0);
    checkOutput("clr_start_time", sw2.time_bcd, 24'h0);
    waitCycles(4);
    checkOutput("clr_start_idle", 24'(sw2.running), 24'h0);
    checkOutput("clr_start_time_held", sw2.time_bcd, 24'h0);

    $display("[TB] lap capture and overflow");
    applyStimulus(START, NONE, 1);
    for (int i = 0; i < 4; i++) begin
      waitCycles(19);
      applyStimulus(LAP, NONE, 0);
    end
    checkOutput("laps_count4", 24'(sw2.lap_count), 24'h4);
    checkOutput("laps_valid", 24'(sw2.lap_valid), 24'h1);
    checkOutput("laps_head_10", sw2.lap_bcd, 24'h000010);
    checkOutput("laps_no_ovf", 24'(sw2.lap_ovf), 24'h0);
    applyStimulus(LAP, NONE, 0);
    checkOutput("lap5_ovf", 24'(sw2.lap_ovf), 24'h1);
    checkOutput("lap5_count", 24'(sw2.lap_count), 24'h4);
    checkOutput("lap5_head", sw2.lap_bcd, 24'h000010);

    exp_heads[0] = 24'h000020;
    exp_heads[1] = 24'h000030;
    exp_heads[2] = 24'h000040;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(RD, NONE, 0);
      checkOutput($sformatf("pop%0d_head", i + 1), sw2.lap_bcd, exp_heads[i]);
    end
    applyStimulus(RD, NONE, 0);
    checkOutput("pop4_valid", 24'(sw2.lap_valid), 24'h0);
    checkOutput("pop4_lapbcd", sw2.lap_bcd, 24'h0);
    checkOutput("pop4_count", 24'(sw2.lap_count), 24'h0);
    applyStimulus(RD, NONE, 0);
    checkOutput("pop_empty_count", 24'(sw2.lap_count), 24'h0);

    applyStimulus(STOP, NONE, 0);
    applyStimulus(CLEAR, NONE, 0);
    checkOutput("clear_ovf", 24'(sw2.lap_ovf), 24'h0);
    checkOutput("clear_time", sw2.time_bcd, 24'h0);
    checkOutput("clear_idle", 24'(sw2.running), 24'h0);

    $display("[TB] simultaneous pulses");
    applyStimulus(START, NONE, 5);
    applyStimulus(LAP | STOP, NONE, 0);
    checkOutput("lapstop_running", 24'(sw2.running), 24'h0);
    checkOutput("lapstop_count", 24'(sw2.lap_count), 24'h1);
    checkOutput("lapstop_captured", sw2.lap_bcd, 24'h000002);
    checkOutput("lapstop_time", sw2.time_bcd, 24'h000003);
    applyStimulus(LAP, NONE, 0);
    checkOutput("lap_in_pause_ignored", 24'(sw2.lap_count), 24'h1);

    applyStimulus(START, NONE, 0);
    applyStimulus(LAP, NONE, 0);
    applyStimulus(LAP, NONE, 0);
    applyStimulus(LAP, NONE, 0);
    checkOutput("refill_count4", 24'(sw2.lap_count), 24'h4);
    applyStimulus(LAP | RD, NONE, 0);
    checkOutput("full_laprd_count", 24'(sw2.lap_count), 24'h4);
    checkOutput("full_laprd_ovf", 24'(sw2.lap_ovf), 24'h0);
    checkOutput("full_laprd_head", sw2.lap_bcd, 24'h000003);
    applyStimulus(STOP, NONE, 0);
    applyStimulus(LAP, NONE, 0);
    checkOutput("full_pause_lap_no_ovf", 24'(sw2.lap_ovf), 24'h0);
    applyStimulus(CLEAR, NONE, 0);

    $display("[TB] reset mid-run");
    applyStimulus(START, NONE, 1);
    applyStimulus(LAP, NONE, 0);
    applyStimulus(LAP, NONE, 0);
    waitCycles(2465);
    checkOutput("midrun_time", sw2.time_bcd, 24'h001234);
    checkOutput("midrun_count", 24'(sw2.lap_count), 24'h2);
    reset = 1'b1;
    waitCycles(1);
    checkAllZero("midrun_reset");
    reset = 1'b0;
    applyStimulus(START, NONE, 0);
    checkOutput("after_reset_start_time", sw2.time_bcd, 24'h0);
    checkOutput("after_reset_running", 24'(sw2.running), 24'h1);
    waitCycles(2);
    checkOutput("after_reset_first_tick", sw2.time_bcd, 24'h000001);

    $display("[TB] full wrap of the time counter");
    bad_digit  = 1'b0;
    early_roll = 1'b0;
    n = 0;
    @(negedge fclk);
    ctr_tick = 1'b1;
    while (ctr_time !== 24'h595999 && n < 400000) begin
      @(negedge fclk);
      n++;
      if (ctr_time.c0 > 4'd9 || ctr_time.c1 > 4'd9 || ctr_time.s0 > 4'd9 ||
          ctr_time.s1 > 4'd5 || ctr_time.m0 > 4'd9 || ctr_time.m1 > 4'd5)
        bad_digit = 1'b1;
      if (ctr_roll !== 1'b0) early_roll = 1'b1;
    end
    checkOutput("wrap_ticks_to_595999", 24'(n), 24'd359999);
    checkOutput("wrap_digits_in_range", 24'(bad_digit), 24'h0);
    checkOutput("wrap_no_early_rollover", 24'(early_roll), 24'h0);
    @(negedge fclk);
    checkOutput("wrap_time_zero", ctr_time, 24'h000000);
    checkOutput("wrap_rollover_pulse", 24'(ctr_roll), 24'h1);
    @(negedge fclk);
    checkOutput("wrap_keeps_counting", ctr_time, 24'h000001);
    checkOutput("wrap_rollover_one_cycle", 24'(ctr_roll), 24'h0);
    ctr_tick = 1'b0;
    ctr_clr  = 1'b1;
    @(negedge fclk);
    ctr_clr  = 1'b0;
    checkOutput("ctr_clr_zero", ctr_time, 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
Parametrised successor to the team's three-block stopwatch (counter, FSM, timer). It integrates a run/pause/clear FSM, a prescaled BCD mm:ss.cc time counter and a lap-capture FIFO. All control inputs are single-cycle, already-debounced pulses. Outputs are BCD digits that feed the seven-segment decode stage.

Parameters:
TICK_DIV, 500000, clk cycles per centisecond tick (500000 gives 100 Hz from 50 MHz); must be >= 2
NUM_LAPS, 4, lap FIFO depth; power of two, 2..16
CNT_W, 19, prescaler width; must satisfy 2**CNT_W >= TICK_DIV

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
start  in  1  pulse: IDLE->RUN or PAUSE->RUN
stop  in  1  pulse: RUN->PAUSE
clear  in  1  pulse: PAUSE->IDLE, zeroes the time and flushes the FIFO
lap  in  1  pulse: capture the current time into the FIFO (honoured in RUN only)
lap_rd  in  1  pulse: pop the FIFO head
time_bcd  out  24  {m1,m0,s1,s0,c1,c0}, 4 bits per digit, m1 is the MSB nibble
lap_bcd  out  24  FIFO head (oldest lap); 0 when the FIFO is empty
lap_valid  out  1  FIFO not empty
lap_count  out  $clog2(NUM_LAPS)+1  number of laps stored
lap_ovf  out  1  sticky: a lap was dropped because the FIFO was full
rollover  out  1  one-cycle pulse when the time wraps from 59:59.99 to 00:00.00
running  out  1  state == RUN

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; prescaler = 0; FIFO empty.
  - All outputs 0.
  - Reset mid-run behaves identically.
- FSM states: IDLE, RUN, PAUSE. Priority within one cycle is clear > stop > start.
  - IDLE: start -> RUN. stop and clear ignored; time is already 0.
  - RUN: stop -> PAUSE. start and clear ignored.
  - PAUSE: clear -> IDLE. If no clear, start -> RUN.
  - State updates on the edge the pulse is sampled. running reflects it the next cycle.
- Prescaler:
  - Counts only in RUN.
  - At TICK_DIV-1 it returns to 0 and issues one tick.
  - Holds its value in PAUSE, so resume keeps the partial tick. Zeroed by clear.
  - First tick lands TICK_DIV cycles after entering RUN from IDLE.
- Time counter (BCD, increments one step per tick):
  - c0 wraps 9->0 and carries into c1; c1 wraps 9->0 and carries into s0.
  - s0 wraps 9->0 and carries into s1; s1 wraps 5->0 and carries into m0.
  - m0 wraps 9->0 and carries into m1; m1 wraps 5->0.
  - At 59:59.99 a tick gives 00:00.00 and rollover=1 for that one cycle; the counter keeps running.
  - No digit ever holds a value > 9, and s1/m1 never hold a value > 5.
- Lap capture:
  - lap in RUN pushes the time_bcd value present before that cycle's edge, i.e. the pre-increment value on a tick cycle.
  - lap and stop in the same cycle: the lap is captured and the state goes to PAUSE.
  - lap outside RUN is ignored and does not set lap_ovf.
  - FIFO full and lap arrives: the lap is dropped, lap_ovf is set, and the FIFO contents are unchanged.
- Lap read:
  - lap_rd with lap_valid pops the head; the next entry appears the following cycle.
  - lap_rd when empty is ignored.
  - lap and lap_rd together when full: pop and push both happen, no overflow, lap_count unchanged.
  - lap and lap_rd together when empty: push only.
- clear (PAUSE only):
  - Zeroes time_bcd and the prescaler.
  - Empties the FIFO and clears lap_ovf.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Package stopwatch_pkg holds:
  - the state enum (IDLE/RUN/PAUSE);
  - the BCD digit type (4 bits) and the time record type (6 digits);
  - digit limit constants (9, 5) and the ZERO_TIME constant.
- Sub-module bcd_time_counter:
  - Inputs: clk, reset, clr, tick.
  - Outputs: time_bcd, rollover.
  - Contains the carry-chain digits; reused by a later countdown variant.
- Lap FIFO is inline: a circular buffer with read/write pointers and a count.

Test Plan:
- Basic run (TICK_DIV=2): reset, start, wait 2*150 cycles -> time_bcd=00:01.50; stop -> value frozen for 50 cycles, running=0.
- Resume partial tick (TICK_DIV=4): stop 2 cycles after a tick, then start -> next increment lands exactly 2 RUN cycles later.
- Rollover (TICK_DIV=2): run to 59:59.99, one more tick -> 00:00.00 with rollover high for exactly 1 cycle; counting continues.
- Laps: capture 4 laps at 00:00.10, .20, .30, .40; a 5th lap -> lap_ovf=1, lap_count=4; lap_rd x4 -> lap_bcd reads .10, .20, .30, .40 in order, then lap_valid=0 and lap_bcd=0.
- Priority/simultaneity:
  - In PAUSE, clear+start together -> IDLE with zeroed time.
  - In RUN, lap+stop together -> lap captured and state PAUSE.
  - With the FIFO full, lap+lap_rd together -> lap_count stays 4 and lap_ovf stays 0.
- Reset mid-run at 00:12.34 with 2 laps stored -> next cycle all outputs 0, state IDLE; a subsequent start counts from 00:00.00.
